// File: rtl/memory_unit_if.sv
// Datapath-to-memory bus bundle for memory_unit.
// The addr_err signal exists only when MEM_BOUNDS_CHECK_EN is defined.
interface memory_unit_if;
    logic [31:0] MAR;
    logic [31:0] data_in;
    logic        Read;
    logic        Write;
    logic [31:0] OUT_MDR;
    logic        Mem_ready;
    logic        busy;
`ifdef MEM_BOUNDS_CHECK_EN
    logic        addr_err;

    modport master (
        output MAR, data_in, Read, Write,
        input  OUT_MDR, Mem_ready, busy, addr_err
    );
    modport slave (
        input  MAR, data_in, Read, Write,
        output OUT_MDR, Mem_ready, busy, addr_err
    );
`else
    modport master (
        output MAR, data_in, Read, Write,
        input  OUT_MDR, Mem_ready, busy
    );
    modport slave (
        input  MAR, data_in, Read, Write,
        output OUT_MDR, Mem_ready, busy
    );
`endif
endinterface

// File: rtl/memory_unit.sv
// Fixed-latency single-port word memory with IDLE/WAIT/DONE request FSM.
// Optional out-of-range detection is enabled by defining MEM_BOUNDS_CHECK_EN.
module memory_unit #(
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned LATENCY = 2
) (
    input logic          clk,
    input logic          reset,
    memory_unit_if.slave mem
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     data_q, data_d;
    logic            wr_q, wr_d;
    logic [31:0]     out_q;
    logic            commit;
    logic            oob_q, oob_d;
    logic [31:0]     mem_q [DEPTH];

`ifdef MEM_BOUNDS_CHECK_EN
    logic            err_q;
    logic            req_oob;
    assign req_oob = (mem.MAR >= 32'(DEPTH));
`else
    logic            req_oob;
    logic            unused_mar_hi;
    assign req_oob       = 1'b0;
    assign unused_mar_hi = ^mem.MAR;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = wr_q;
        oob_d   = oob_q;
        commit  = 1'b0;
        case (state_q)
            StIdle: begin
                if (mem.Read || mem.Write) begin
                    state_d = StWait;
                    cnt_d   = 4'(LATENCY - 1);
                    addr_d  = mem.MAR[AW-1:0];
                    data_d  = mem.data_in;
                    // Write wins when both requests are raised together.
                    wr_d    = mem.Write;
                    oob_d   = req_oob;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StDone;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            data_q  <= 32'h0;
            wr_q    <= 1'b0;
            oob_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            oob_q   <= oob_d;
        end
    end

    // Storage has no reset; an aborted access never reaches its commit edge.
    always_ff @(posedge clk) begin
        if (!reset && commit && wr_q && !oob_q) begin
            mem_q[addr_q] <= data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= 32'h0;
        end else if (commit && !wr_q) begin
            out_q <= oob_q ? 32'h0 : mem_q[addr_q];
        end
    end

`ifdef MEM_BOUNDS_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (commit && oob_q) begin
            err_q <= 1'b1;
        end
    end
    assign mem.addr_err = err_q;
`endif

    assign mem.OUT_MDR   = out_q;
    assign mem.Mem_ready = (state_q == StDone);
    assign mem.busy      = (state_q != StIdle);
endmodule
